// File: rtl/frame_dispatch.sv
// Byte-stream frame assembler and dispatcher for the switch-side frame serial interface.
// Builds MSB-first frames and issues each one with a one-hot or broadcast load strobe.
module frame_dispatch #(
    parameter int NUM_SW_INST = 5,
    parameter int FRAME_WIDTH = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    output logic                   byte_ready,
    output logic [NUM_SW_INST-1:0] load_out,
    output logic [FRAME_WIDTH-1:0] frame_out,
    output logic                   err_addr,
    output logic                   err_timeout,
    output logic [7:0]             err_cnt,
    output logic                   busy
);

    localparam int BYTES = FRAME_WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready drops only in ISSUE, and the source must hold its byte until taken.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [FRAME_WIDTH-1:0] asm_q, asm_d;
    logic [NUM_SW_INST-1:0] load_d;
    logic [7:0]             unit_id;
    logic                   accept;
    logic                   final_byte;
    logic                   id_valid;
    logic                   id_bcast;
    logic                   issue_go;
    logic                   addr_err;
    logic                   tmo_err;

    assign byte_ready = (state_q != ISSUE);
    assign busy       = (state_q != IDLE);
    assign accept     = byte_valid && byte_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        issue_go   = 1'b0;
        addr_err   = 1'b0;
        tmo_err    = 1'b0;
        final_byte = 1'b0;

        if (accept && state_q == IDLE) begin
            asm_d = '0;
        end
        // Byte count selects the lane: count 0 lands in the top byte.
        if (accept) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cnt_q == CNT_W'(BYTES - 1 - i)) begin
                    asm_d[i*8 +: 8] = byte_in;
                end
            end
        end

        unit_id  = asm_d[FRAME_WIDTH-1 -: 8];
        id_valid = ({24'd0, unit_id} < 32'(NUM_SW_INST));
        id_bcast = (unit_id == 8'hFF);
        for (int i = 0; i < NUM_SW_INST; i++) begin
            load_d[i] = id_bcast || (unit_id == 8'(i));
        end

        final_byte = accept && (cnt_q == CNT_W'(BYTES - 1));

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    state_d = COLLECT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COLLECT: begin
                if (accept) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_err = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (final_byte) begin
            cnt_d = '0;
            tmo_d = '0;
            if (id_valid || id_bcast) begin
                issue_go = 1'b1;
                state_d  = ISSUE;
            end else begin
                addr_err = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            asm_q       <= '0;
            load_out    <= '0;
            frame_out   <= '0;
            err_addr    <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            asm_q       <= asm_d;
            load_out    <= issue_go ? load_d : '0;
            err_addr    <= addr_err;
            err_timeout <= tmo_err;
            if (issue_go) begin
                frame_out <= asm_d;
            end
            if ((addr_err || tmo_err) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/frame_dispatch.md
Name: frame_dispatch

Overview:
- Upstream stage of the switch-side frame serial interface.
- Takes a byte stream over a valid/ready handshake and assembles FRAME_WIDTH-bit frames, MSB byte first.
- Decodes the destination unit ID and issues each frame with a one-cycle one-hot (or broadcast) load strobe, one bit per switch instance.
- Discards stalled partial frames on timeout and counts protocol errors.

Parameters:
- NUM_SW_INST, 5: number of switch instances; width of load_out; must be 1..254.
- FRAME_WIDTH, 32: frame width in bits; fixed multiple of 8; BYTES = FRAME_WIDTH/8 (4 at default).
- TIMEOUT_CYC, 16: idle cycles tolerated between bytes of one frame before the partial frame is discarded; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- byte_valid  input  1  byte_in carries a byte
- byte_in  input  8  stream byte
- byte_ready  output  1  block accepts a byte this cycle; a byte transfers when byte_valid && byte_ready
- load_out  output  NUM_SW_INST  one-cycle load strobe, one bit per switch instance
- frame_out  output  FRAME_WIDTH  last successfully decoded frame; held between frames
- err_addr  output  1  one-cycle pulse: frame discarded for invalid unit ID
- err_timeout  output  1  one-cycle pulse: partial frame discarded on timeout
- err_cnt  output  8  saturating count of all errors
- busy  output  1  high while state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE; byte counter 0; timeout counter 0; assembly register 0.
  - load_out 0; frame_out 0; err_addr 0; err_timeout 0; err_cnt 0; busy 0; byte_ready 1 immediately after rst deasserts.
- States:
  - IDLE: no bytes held. byte_ready=1. An accept stores the byte into frame bits [FRAME_WIDTH-1 -: 8], sets byte count 1, and moves to COLLECT.
  - COLLECT: 1..BYTES-1 bytes held. byte_ready=1. Each accept shifts the byte into the next-lower byte lane.
  - ISSUE: entered only for a valid frame. byte_ready=0. load_out is high for exactly this cycle. Always returns to IDLE on the next edge.
- Final byte: on the edge accepting byte BYTES, the complete frame is decoded.
  - unit_id = frame[FRAME_WIDTH-1 -: 8]; the remaining bits are passed through untouched.
  - unit_id < NUM_SW_INST: frame_out <= frame; load_out <= one-hot(unit_id); go to ISSUE.
  - unit_id == 8'hFF (broadcast): frame_out <= frame; load_out <= all ones; go to ISSUE.
  - Any other unit_id: frame_out unchanged; load_out stays 0; err_addr pulses in the next cycle; err_cnt increments; go directly to IDLE.
- Latency: load_out and the new frame_out are both valid in the cycle after the final byte's accept edge. frame_out is registered and stable for the whole load_out cycle and afterwards.
- Throughput: at most one frame per BYTES+1 cycles (5 at default). byte_ready is low only in ISSUE.
- Timeout:
  - The timeout counter runs only in COLLECT.
  - It clears on every accept and increments on every COLLECT cycle without an accept.
  - If no accept occurs for TIMEOUT_CYC consecutive cycles (last accept at edge E, abort at edge E+TIMEOUT_CYC), the partial frame is dropped: state -> IDLE, byte count 0, err_timeout pulses for one cycle, err_cnt increments. frame_out is unchanged.
  - An accept in the same cycle the timeout would fire wins: no abort, and the counter clears.
- err_cnt saturates at 255 and never wraps. err_addr and err_timeout never assert in the same cycle.
- A byte presented with byte_valid=1 during ISSUE is not accepted. It must be held by the source and is taken in the following IDLE cycle.
- Reset mid-frame or during ISSUE discards everything asynchronously. No load_out or error pulse is produced for the interrupted frame.

Test Plan:
- Reset, then bytes 02,0A,5C,11 back-to-back → load_out=5'b00100 exactly one cycle after byte 4's accept edge; frame_out=32'h020A5C11; byte_ready=0 that cycle, 1 the next.
- Bytes FF,00,00,01 → load_out=5'b11111 for one cycle; frame_out=32'hFF000001.
- Valid frame 01,00,00,00, then bytes 07,12,34,56 → no load_out; err_addr one-cycle pulse; err_cnt=1; frame_out stays 32'h01000000.
- Bytes 03,AA, then byte_valid=0 for 16 cycles → err_timeout pulses at edge 16 after the last accept; err_cnt+1. Following frame 00,01,02,03 → load_out=5'b00001, frame_out=32'h00010203. Repeat with a byte arriving on cycle 16 → no timeout.
- byte_valid held high continuously with two back-to-back frames → second frame's first byte stalled exactly one cycle (ISSUE); both frames issued 5 cycles apart.
- rst pulsed after 2 bytes → all outputs 0; next full frame decoded correctly. 300 bad-ID frames → err_cnt=255, no wrap.
